// File: rtl/harvard_run_monitor.sv
// Program ROM plus run monitor: serves CPU fetches, sequences a run, and grades it at halt.
// Latency: ROM read is combinational; halt, bad-fetch and timeout verdicts register on the sampling edge.
// Flow control: none; clk_enable low freezes the FSM, counters and ROM writes, and reads stay live.
module harvard_run_monitor #(
    parameter int          ROM_DEPTH      = 16,
    parameter logic [31:0] RESET_VECTOR   = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR      = 32'h00000000,
    parameter int          TIMEOUT_CYCLES = 1000,
    parameter int          CNT_W          = 16,
    localparam int         IDX_W          = $clog2(ROM_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_enable,
    input  logic             load_en,
    input  logic [IDX_W-1:0] load_index,
    input  logic [31:0]      load_word,
    input  logic             start,
    input  logic [31:0]      expected_v0,
    output logic             cpu_reset,
    input  logic [31:0]      instr_address,
    output logic [31:0]      instr_readdata,
    input  logic             active,
    input  logic [31:0]      register_v0,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RELEASE = 2'd1,
        S_RUN     = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0]       FC_NONE     = 2'd0;
    localparam logic [1:0]       FC_V0       = 2'd1;
    localparam logic [1:0]       FC_TIMEOUT  = 2'd2;
    localparam logic [1:0]       FC_BADFETCH = 2'd3;
    localparam logic [31:0]      ROM_SPAN    = 32'(ROM_DEPTH * 4);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic             cpu_reset_q;
    logic             done_q;
    logic             pass_q;
    logic [1:0]       fail_code_q;
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] fetch_q;
    logic [31:0]      exp_v0_q;

    logic [31:0]      rom_q [ROM_DEPTH];

    logic [31:0]      offset_d;
    logic             in_range_d;
    logic [IDX_W-1:0] rom_idx_d;
    logic             halt_d;
    logic             bad_fetch_d;
    logic             timeout_d;
    logic             v0_match_d;
    logic [CNT_W-1:0] cycle_d;
    logic [CNT_W-1:0] fetch_d;

    // Address decode, ROM read and run-event detection (addresses below the vector wrap to large offsets)
    always_comb begin
        offset_d       = instr_address - RESET_VECTOR;
        in_range_d     = (offset_d < ROM_SPAN) && (offset_d[1:0] == 2'b00);
        rom_idx_d      = offset_d[IDX_W+1:2];
        instr_readdata = in_range_d ? rom_q[rom_idx_d] : 32'h00000000;
        halt_d         = (instr_address == HALT_ADDR) || !active;
        bad_fetch_d    = !in_range_d && !halt_d;
        v0_match_d     = (register_v0 == exp_v0_q);
        cycle_d        = (&cycle_q) ? cycle_q : cycle_q + 1'b1;
        fetch_d        = (&fetch_q) ? fetch_q : fetch_q + 1'b1;
        timeout_d      = (cycle_d == TIMEOUT_LAST);
    end

    // ROM loading: only while idle, and contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (clk_enable && load_en && (state_q == S_IDLE)) begin
            rom_q[load_index] <= load_word;
        end
    end

    // Run sequencer with registered verdict outputs; halt outranks bad fetch, which outranks timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_code_q <= FC_NONE;
            cycle_q     <= '0;
            fetch_q     <= '0;
            exp_v0_q    <= '0;
        end else if (clk_enable) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q     <= S_RELEASE;
                        exp_v0_q    <= expected_v0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        fail_code_q <= FC_NONE;
                        cycle_q     <= '0;
                        fetch_q     <= '0;
                    end
                end
                S_RELEASE: begin
                    state_q     <= S_RUN;
                    cpu_reset_q <= 1'b0;
                    cycle_q     <= '0;
                    fetch_q     <= '0;
                end
                S_RUN: begin
                    cycle_q <= cycle_d;
                    if (in_range_d) begin
                        fetch_q <= fetch_d;
                    end
                    if (halt_d) begin
                        state_q     <= S_DONE;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b1;
                        pass_q      <= v0_match_d;
                        fail_code_q <= v0_match_d ? FC_NONE : FC_V0;
                    end else if (bad_fetch_d) begin
                        state_q     <= S_DONE;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_BADFETCH;
                    end else if (timeout_d) begin
                        state_q     <= S_DONE;
                        cpu_reset_q <= 1'b1;
                        done_q      <= 1'b1;
                        fail_code_q <= FC_TIMEOUT;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign cpu_reset   = cpu_reset_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = fail_code_q;
    assign cycle_count = cycle_q;
    assign fetch_count = fetch_q;

endmodule

// File: tb/tb_harvard_run_monitor.sv
// Bench for harvard_run_monitor: a small MIPS-subset CPU stand-in drives fetches,
// expected run verdicts are queued at start and compared when done rises.
module tb_harvard_run_monitor;

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] HALT = 32'h00000000;

    logic        clk;
    logic        reset;
    logic        clk_enable;
    logic        load_en;
    logic [3:0]  load_index;
    logic [31:0] load_word;
    logic        start;
    logic [31:0] expected_v0;
    logic        cpu_reset;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        active;
    logic [31:0] register_v0;
    logic        done;
    logic        pass;
    logic [1:0]  fail_code;
    logic [15:0] cycle_count;
    logic [15:0] fetch_count;

    harvard_run_monitor #(
        .ROM_DEPTH      (16),
        .RESET_VECTOR   (RV),
        .HALT_ADDR      (HALT),
        .TIMEOUT_CYCLES (50),
        .CNT_W          (16)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .clk_enable     (clk_enable),
        .load_en        (load_en),
        .load_index     (load_index),
        .load_word      (load_word),
        .start          (start),
        .expected_v0    (expected_v0),
        .cpu_reset      (cpu_reset),
        .instr_address  (instr_address),
        .instr_readdata (instr_readdata),
        .active         (active),
        .register_v0    (register_v0),
        .done           (done),
        .pass           (pass),
        .fail_code      (fail_code),
        .cycle_count    (cycle_count),
        .fetch_count    (fetch_count)
    );

    typedef struct {
        logic [31:0] pass_e;
        logic [31:0] code_e;
        logic [31:0] cyc_e;
        logic [31:0] fet_e;
    } exp_t;

    exp_t        sb_q[$];
    int          checks   = 0;
    int          failures = 0;
    string       cur      = "init";

    // CPU stand-in state
    logic [31:0] regs [32];
    logic [31:0] pc;
    logic [31:0] npc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s/%s got=%h exp=%h", cur, tag, got, exp);
        end
    endtask

    task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        instr_address = addr;
        #1;
        chk(tag, instr_readdata, exp);
    endtask

    task automatic load(input int idx, input logic [31:0] w);
        @(negedge clk);
        load_en    = 1'b1;
        load_index = 4'(idx);
        load_word  = w;
        @(negedge clk);
        load_en    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Start edge: IDLE/DONE -> RELEASE; results cleared, CPU still held
    task automatic do_start(input logic [31:0] ev);
        @(negedge clk);
        expected_v0 = ev;
        start       = 1'b1;
        @(negedge clk);
        start       = 1'b0;
        expected_v0 = 32'hDEADBEEF;
        chk("rel_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rel_done", 32'(done), 32'd0);
        chk("rel_fail", 32'(fail_code), 32'd0);
        chk("rel_cyc", 32'(cycle_count), 32'd0);
    endtask

    // Execute one instruction (addiu, j, jr, beq) with a branch delay slot
    task automatic cpu_step();
        logic [31:0] ir;
        logic [31:0] simm;
        logic [31:0] nn;
        ir   = instr_readdata;
        simm = {{16{ir[15]}}, ir[15:0]};
        nn   = npc + 32'd4;
        case (ir[31:26])
            6'h00: if (ir[5:0] == 6'h08) nn = regs[ir[25:21]];
            6'h02: nn = {npc[31:28], ir[25:0], 2'b00};
            6'h04: if (regs[ir[25:21]] == regs[ir[20:16]]) nn = npc + (simm << 2);
            6'h09: if (ir[20:16] != 5'd0) regs[ir[20:16]] = regs[ir[25:21]] + simm;
            default: ;
        endcase
        pc            = npc;
        npc           = nn;
        instr_address = pc;
        register_v0   = regs[2];
    endtask

    task automatic sb_pop_check();
        exp_t e;
        chk("sb_depth", 32'(sb_q.size()), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("done", 32'(done), 32'd1);
            chk("pass", 32'(pass), e.pass_e);
            chk("fail_code", 32'(fail_code), e.code_e);
            chk("cycle_count", 32'(cycle_count), e.cyc_e);
            chk("fetch_count", 32'(fetch_count), e.fet_e);
            chk("done_cpu_reset", 32'(cpu_reset), 32'd1);
        end
    endtask

    task automatic run_test(input string name, input logic [31:0] ev, input bit tamper,
                            input int ep, input int ec, input int ecyc, input int efet);
        exp_t e;
        cur = name;
        e.pass_e = 32'(ep);
        e.code_e = 32'(ec);
        e.cyc_e  = 32'(ecyc);
        e.fet_e  = 32'(efet);
        sb_q.push_back(e);
        foreach (regs[i]) regs[i] = '0;
        pc            = RV;
        npc           = RV + 32'd4;
        instr_address = pc;
        register_v0   = '0;
        active        = 1'b1;
        do_start(ev);
        if (tamper) begin
            load_en    = 1'b1;
            load_index = 4'd0;
            load_word  = 32'hFFFFFFFF;
        end
        @(negedge clk);
        chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            cpu_step();
        end
        chk("done_seen", 32'(done), 32'd1);
        @(negedge clk);
        load_en = 1'b0;
        sb_pop_check();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset         = 1'b0;
        clk_enable    = 1'b1;
        load_en       = 1'b0;
        load_index    = '0;
        load_word     = '0;
        start         = 1'b0;
        expected_v0   = '0;
        instr_address = '0;
        active        = 1'b1;
        register_v0   = '0;
        repeat (2) @(negedge clk);
        chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_fail", 32'(fail_code), 32'd0);
        chk("rst_cyc", 32'(cycle_count), 32'd0);
        chk("rst_fet", 32'(fetch_count), 32'd0);
        reset = 1'b1;

        cur = "rom";
        load(0, 32'h24420008);
        load(1, 32'h24420002);
        load(2, 32'h00000008);
        load(3, 32'h24000000);
        rd_check("rd_word1", RV + 32'd4, 32'h24420002);
        rd_check("rd_misaligned", RV + 32'd2, 32'h00000000);
        rd_check("rd_past_end", RV + 32'd64, 32'h00000000);
        rd_check("rd_below", RV - 32'd4, 32'h00000000);

        run_test("v0_pass", 32'd10, 1'b0, 1, 0, 5, 4);
        run_test("v0_wrong", 32'd11, 1'b0, 0, 1, 5, 4);
        run_test("load_in_run", 32'd10, 1'b1, 1, 0, 5, 4);
        cur = "load_in_run";
        rd_check("rom_unchanged", RV, 32'h24420008);
        run_test("rerun", 32'd10, 1'b0, 1, 0, 5, 4);

        // Freeze with clk_enable low, then asynchronous reset mid-run
        cur = "freeze";
        instr_address = RV;
        active        = 1'b1;
        register_v0   = '0;
        do_start(32'd10);
        @(negedge clk);
        repeat (3) @(negedge clk);
        chk("cyc_before", 32'(cycle_count), 32'd3);
        chk("fet_before", 32'(fetch_count), 32'd3);
        clk_enable = 1'b0;
        rd_check("rd_frozen", RV + 32'd4, 32'h24420002);
        instr_address = HALT;
        active        = 1'b0;
        repeat (5) @(negedge clk);
        chk("cyc_frozen", 32'(cycle_count), 32'd3);
        chk("fet_frozen", 32'(fetch_count), 32'd3);
        chk("done_frozen", 32'(done), 32'd0);
        chk("cpu_reset_frozen", 32'(cpu_reset), 32'd0);
        clk_enable    = 1'b1;
        instr_address = RV + 32'd8;
        active        = 1'b1;
        @(negedge clk);
        chk("cyc_resume", 32'(cycle_count), 32'd4);
        chk("fet_resume", 32'(fetch_count), 32'd4);
        #2 reset = 1'b0;
        #1;
        chk("ar_cpu_reset", 32'(cpu_reset), 32'd1);
        chk("ar_done", 32'(done), 32'd0);
        chk("ar_pass", 32'(pass), 32'd0);
        chk("ar_fail", 32'(fail_code), 32'd0);
        chk("ar_cyc", 32'(cycle_count), 32'd0);
        chk("ar_fet", 32'(fetch_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        rd_check("rom_kept", RV, 32'h24420008);

        // Branch-to-self loop runs into the timeout
        load(0, 32'h1000FFFF);
        load(1, 32'h00000000);
        run_test("timeout", 32'd0, 1'b0, 0, 2, 49, 49);

        // Jump past the end of the ROM
        do_reset();
        load(0, 32'h0BF00040);
        load(1, 32'h00000000);
        run_test("bad_fetch", 32'd0, 1'b0, 0, 3, 3, 2);

        // Halt fetch on the same edge that would time out
        begin
            exp_t e;
            cur      = "halt_vs_timeout";
            e.pass_e = 32'd1;
            e.code_e = 32'd0;
            e.cyc_e  = 32'd49;
            e.fet_e  = 32'd48;
            sb_q.push_back(e);
            instr_address = RV;
            active        = 1'b1;
            register_v0   = 32'd5;
            do_start(32'd5);
            @(negedge clk);
            repeat (48) @(negedge clk);
            chk("cyc_pre", 32'(cycle_count), 32'd48);
            chk("done_pre", 32'(done), 32'd0);
            instr_address = HALT;
            @(negedge clk);
            sb_pop_check();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
